// File: rtl/ibex_fetch_fifo.sv
// ibex_fetch_fifo
// Instruction fetch buffer between the instruction memory interface and the
// IF stage. Holds up to NUM_REQS+1 fetched 32-bit words in an in-order queue
// and re-aligns them so that 16-bit compressed and 32-bit instructions can be
// presented at halfword-aligned PCs.
//
// Ports:
//   clk_i        clock, all state on rising edge
//   rst_ni       asynchronous active-low reset
//   clear_i      flush all entries and load in_addr_i as the new fetch PC
//   in_addr_i    branch target, sampled only when clear_i=1
//   in_valid_i   memory response word valid
//   in_rdata_i   memory response word (word-aligned)
//   in_err_i     bus/PMP error for the response word
//   busy_o       busy_o[i] = queue entry (DEPTH-NUM_REQS+i) occupied
//   out_valid_o  complete instruction (or error) available
//   out_ready_i  IF stage consumes the presented instruction
//   out_addr_o   PC of the presented instruction
//   out_rdata_o  halfword-realigned instruction bits
//   out_err_o    fetch error for the presented instruction
//
// Configuration macro: IBEX_FETCH_FIFO_BYPASS_EN
//   defined   : incoming words feed the output mux combinationally when the
//               words they complete are not yet stored (zero latency)
//   undefined : every word is registered first (one cycle latency)
module ibex_fetch_fifo #(
  parameter int unsigned NUM_REQS = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic [31:0]         in_addr_i,
  input  logic                in_valid_i,
  input  logic [31:0]         in_rdata_i,
  input  logic                in_err_i,
  output logic [NUM_REQS-1:0] busy_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [31:0]         out_addr_o,
  output logic [31:0]         out_rdata_o,
  output logic                out_err_o
);

  localparam int unsigned DEPTH = NUM_REQS + 1;

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_err;
  logic [31:0]      r_rdata [DEPTH];
  logic [31:0]      r_instrAddr;

  logic             w_inValid;
  logic             w_valid0, w_valid1, w_err0, w_err1;
  logic [31:0]      w_rdata0, w_rdata1;
  logic             w_unalignedComp;
  logic             w_outComp;
  logic             w_fire;
  logic             w_pop;
  logic [DEPTH:0]   w_slotFree;
  logic [DEPTH:0]   w_extValid;
  logic [DEPTH:0]   w_extErr;
  logic [31:0]      w_extRdata [DEPTH+1];
  logic [DEPTH-1:0] w_nextValid;
  logic [DEPTH-1:0] w_nextErr;
  logic [31:0]      w_nextRdata [DEPTH];

  // A response arriving in a clear cycle belongs to the old fetch stream.
  assign w_inValid = in_valid_i & ~clear_i;

  // Views of the two oldest words used by the output mux.
`ifdef IBEX_FETCH_FIFO_BYPASS_EN
  // The incoming word stands in for the first missing stored word.
  always_comb begin
    w_valid0 = r_valid[0] | w_inValid;
    w_rdata0 = r_valid[0] ? r_rdata[0] : in_rdata_i;
    w_err0   = r_valid[0] ? r_err[0]   : (w_inValid & in_err_i);
    w_valid1 = r_valid[1] | (r_valid[0] & w_inValid);
    w_rdata1 = r_valid[1] ? r_rdata[1] : in_rdata_i;
    w_err1   = r_valid[1] ? r_err[1]   : (w_inValid & in_err_i);
  end
`else
  always_comb begin
    w_valid0 = r_valid[0];
    w_rdata0 = r_rdata[0];
    w_err0   = r_err[0];
    w_valid1 = r_valid[1];
    w_rdata1 = r_rdata[1];
    w_err1   = r_err[1];
  end
`endif

  assign w_unalignedComp = (w_rdata0[17:16] != 2'b11);

  // Output mux: an unaligned instruction is complete with only entry0 when it
  // is compressed, or when entry0 already carries an error.
  always_comb begin
    out_rdata_o = w_rdata0;
    out_valid_o = w_valid0;
    out_err_o   = w_err0;
    if (r_instrAddr[1]) begin
      out_rdata_o = {w_rdata1[15:0], w_rdata0[31:16]};
      out_valid_o = w_valid1 | (w_valid0 & (w_unalignedComp | w_err0));
      out_err_o   = w_err0 | (w_err1 & ~w_unalignedComp);
    end
  end

  assign out_addr_o = r_instrAddr;
  assign busy_o     = r_valid[DEPTH-1 -: NUM_REQS];

  assign w_outComp = (out_rdata_o[1:0] != 2'b11);
  assign w_fire    = out_valid_o & out_ready_i & ~clear_i;
  // Aligned compressed leaves the upper half of entry0 still to be consumed.
  assign w_pop     = w_fire & (r_instrAddr[1] | ~w_outComp);

  // Slot i is the lowest free one when it is empty and slot i-1 is occupied;
  // slot DEPTH is a virtual slot that only exists for push-with-pop on a full
  // queue, where the shift frees the last real entry.
  assign w_slotFree = ~{1'b0, r_valid} & {r_valid, 1'b1};

  // Stored queue with the incoming word appended, then shifted on pop.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_extValid[i] = r_valid[i];
      w_extErr[i]   = r_err[i];
      w_extRdata[i] = r_rdata[i];
    end
    w_extValid[DEPTH] = 1'b0;
    w_extErr[DEPTH]   = 1'b0;
    w_extRdata[DEPTH] = 32'h0;
    for (int i = 0; i <= DEPTH; i++) begin
      if (w_inValid && w_slotFree[i]) begin
        w_extValid[i] = 1'b1;
        w_extErr[i]   = in_err_i;
        w_extRdata[i] = in_rdata_i;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      w_nextValid[i] = w_pop ? w_extValid[i+1] : w_extValid[i];
      w_nextErr[i]   = w_pop ? w_extErr[i+1]   : w_extErr[i];
      w_nextRdata[i] = w_pop ? w_extRdata[i+1] : w_extRdata[i];
    end
  end

  // Queue storage; clear only drops the valid bits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= '0;
      r_err   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rdata[i] <= 32'h0;
      end
    end else if (clear_i) begin
      r_valid <= '0;
    end else begin
      r_valid <= w_nextValid;
      r_err   <= w_nextErr;
      for (int i = 0; i < DEPTH; i++) begin
        r_rdata[i] <= w_nextRdata[i];
      end
    end
  end

  // Fetch PC: advances by the size of each consumed instruction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_instrAddr <= 32'h0;
    end else if (clear_i) begin
      r_instrAddr <= in_addr_i;
    end else if (w_fire) begin
      r_instrAddr <= r_instrAddr + (w_outComp ? 32'd2 : 32'd4);
    end
  end

  // Upstream must hold off requests using busy_o so the queue never overflows.
  noOverflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(w_inValid && r_valid[DEPTH-1] && !w_pop));

endmodule

// File: tb/tb_ibex_fetch_fifo.sv
// tb_ibex_fetch_fifo
// Directed testbench for ibex_fetch_fifo (NUM_REQS=2). Each task drives one
// scenario and checks outputs against hand-computed values. Inputs change
// 1ns after the rising edge; outputs are sampled in that same settled window.
module tb_ibex_fetch_fifo;

  logic        clk_i;
  logic        rst_ni;
  logic        clear_i;
  logic [31:0] in_addr_i;
  logic        in_valid_i;
  logic [31:0] in_rdata_i;
  logic        in_err_i;
  logic [1:0]  busy_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_addr_o;
  logic [31:0] out_rdata_o;
  logic        out_err_o;

  int assertCount = 0;
  int failCount   = 0;

`ifdef IBEX_FETCH_FIFO_BYPASS_EN
  localparam logic ExpSameCycleValid = 1'b1;
`else
  localparam logic ExpSameCycleValid = 1'b0;
`endif

  ibex_fetch_fifo #(.NUM_REQS(2)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .in_addr_i   (in_addr_i),
    .in_valid_i  (in_valid_i),
    .in_rdata_i  (in_rdata_i),
    .in_err_i    (in_err_i),
    .busy_o      (busy_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_addr_o  (out_addr_o),
    .out_rdata_o (out_rdata_o),
    .out_err_o   (out_err_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clearTo(input logic [31:0] addr);
    clear_i   = 1'b1;
    in_addr_i = addr;
    tick();
    clear_i   = 1'b0;
  endtask

  task automatic pushWord(input logic [31:0] data, input logic err);
    in_valid_i = 1'b1;
    in_rdata_i = data;
    in_err_i   = err;
    tick();
    in_valid_i = 1'b0;
    in_err_i   = 1'b0;
  endtask

  task automatic consume();
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    assertCount++; if (out_valid_o !== 1'b0) begin failCount++; $display("[TB] FAIL reset_valid: got %0b expected 0", out_valid_o); end
    assertCount++; if (busy_o !== 2'b00) begin failCount++; $display("[TB] FAIL reset_busy: got %b expected 00", busy_o); end
    assertCount++; if (out_addr_o !== 32'h0) begin failCount++; $display("[TB] FAIL reset_addr: got %h expected 00000000", out_addr_o); end
    assertCount++; if (out_err_o !== 1'b0) begin failCount++; $display("[TB] FAIL reset_err: got %0b expected 0", out_err_o); end
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_idle_ready();
    clearTo(32'h600);
    consume();
    assertCount++; if (out_addr_o !== 32'h600) begin failCount++; $display("[TB] FAIL idle_ready_addr: got %h expected 00000600", out_addr_o); end
    assertCount++; if (out_valid_o !== 1'b0) begin failCount++; $display("[TB] FAIL idle_ready_valid: got %0b expected 0", out_valid_o); end
  endtask

  task automatic test_aligned();
    clearTo(32'h80);
    assertCount++; if (out_addr_o !== 32'h80) begin failCount++; $display("[TB] FAIL aligned_clear_addr: got %h expected 00000080", out_addr_o); end
    in_valid_i = 1'b1;
    in_rdata_i = 32'h00412083;
    #1;
    assertCount++; if (out_valid_o !== ExpSameCycleValid) begin failCount++; $display("[TB] FAIL aligned_latency: got %0b expected %0b", out_valid_o, ExpSameCycleValid); end
    tick();
    in_valid_i = 1'b0;
    assertCount++; if (out_valid_o !== 1'b1) begin failCount++; $display("[TB] FAIL aligned_valid: got %0b expected 1", out_valid_o); end
    assertCount++; if (out_rdata_o !== 32'h00412083) begin failCount++; $display("[TB] FAIL aligned_rdata: got %h expected 00412083", out_rdata_o); end
    assertCount++; if (out_addr_o !== 32'h80) begin failCount++; $display("[TB] FAIL aligned_addr: got %h expected 00000080", out_addr_o); end
    consume();
    assertCount++; if (out_addr_o !== 32'h84) begin failCount++; $display("[TB] FAIL aligned_next_addr: got %h expected 00000084", out_addr_o); end
    assertCount++; if (out_valid_o !== 1'b0 || busy_o !== 2'b00) begin failCount++; $display("[TB] FAIL aligned_empty: got valid=%0b busy=%b expected valid=0 busy=00", out_valid_o, busy_o); end
  endtask

  task automatic test_compressed();
    clearTo(32'h100);
    pushWord(32'h45014501, 1'b0);
    assertCount++; if (out_valid_o !== 1'b1 || out_rdata_o[15:0] !== 16'h4501) begin failCount++; $display("[TB] FAIL comp_first: got valid=%0b rdata=%h expected valid=1 rdata[15:0]=4501", out_valid_o, out_rdata_o); end
    consume();
    assertCount++; if (out_addr_o !== 32'h102) begin failCount++; $display("[TB] FAIL comp_second_addr: got %h expected 00000102", out_addr_o); end
    assertCount++; if (out_valid_o !== 1'b1 || out_rdata_o[15:0] !== 16'h4501) begin failCount++; $display("[TB] FAIL comp_second: got valid=%0b rdata=%h expected valid=1 rdata[15:0]=4501", out_valid_o, out_rdata_o); end
    consume();
    assertCount++; if (out_addr_o !== 32'h104) begin failCount++; $display("[TB] FAIL comp_final_addr: got %h expected 00000104", out_addr_o); end
    assertCount++; if (out_valid_o !== 1'b0) begin failCount++; $display("[TB] FAIL comp_popped: got valid=%0b expected 0", out_valid_o); end
  endtask

  task automatic test_unaligned();
    clearTo(32'h102);
    pushWord(32'h20830000, 1'b0);
    assertCount++; if (out_valid_o !== 1'b0) begin failCount++; $display("[TB] FAIL unal_half_valid: got %0b expected 0", out_valid_o); end
    pushWord(32'h00000041, 1'b0);
    assertCount++; if (out_valid_o !== 1'b1) begin failCount++; $display("[TB] FAIL unal_valid: got %0b expected 1", out_valid_o); end
    assertCount++; if (out_rdata_o !== 32'h00412083) begin failCount++; $display("[TB] FAIL unal_rdata: got %h expected 00412083", out_rdata_o); end
    assertCount++; if (busy_o !== 2'b01) begin failCount++; $display("[TB] FAIL unal_busy: got %b expected 01", busy_o); end
    consume();
    assertCount++; if (out_addr_o !== 32'h106) begin failCount++; $display("[TB] FAIL unal_next_addr: got %h expected 00000106", out_addr_o); end
    assertCount++; if (busy_o !== 2'b00) begin failCount++; $display("[TB] FAIL unal_pop_busy: got %b expected 00", busy_o); end
  endtask

  task automatic test_error();
    clearTo(32'h202);
    pushWord(32'h20830000, 1'b0);
    pushWord(32'h00000000, 1'b1);
    assertCount++; if (out_valid_o !== 1'b1 || out_err_o !== 1'b1) begin failCount++; $display("[TB] FAIL err_uncomp: got valid=%0b err=%0b expected valid=1 err=1", out_valid_o, out_err_o); end
    clearTo(32'h202);
    pushWord(32'h45010000, 1'b0);
    assertCount++; if (out_valid_o !== 1'b1) begin failCount++; $display("[TB] FAIL err_comp_single: got valid=%0b expected 1", out_valid_o); end
    pushWord(32'h00000000, 1'b1);
    assertCount++; if (out_valid_o !== 1'b1 || out_err_o !== 1'b0) begin failCount++; $display("[TB] FAIL err_comp: got valid=%0b err=%0b expected valid=1 err=0", out_valid_o, out_err_o); end
  endtask

  task automatic test_back_to_back();
    clearTo(32'h500);
    pushWord(32'h00100093, 1'b0);
    pushWord(32'h00200113, 1'b0);
    out_ready_i = 1'b1;
    pushWord(32'h00300193, 1'b0);
    out_ready_i = 1'b0;
    assertCount++; if (out_rdata_o !== 32'h00200113 || out_addr_o !== 32'h504) begin failCount++; $display("[TB] FAIL b2b_first: got rdata=%h addr=%h expected 00200113/00000504", out_rdata_o, out_addr_o); end
    assertCount++; if (busy_o !== 2'b01) begin failCount++; $display("[TB] FAIL b2b_busy: got %b expected 01", busy_o); end
    consume();
    assertCount++; if (out_rdata_o !== 32'h00300193 || out_addr_o !== 32'h508) begin failCount++; $display("[TB] FAIL b2b_second: got rdata=%h addr=%h expected 00300193/00000508", out_rdata_o, out_addr_o); end
    consume();
    assertCount++; if (out_valid_o !== 1'b0 || out_addr_o !== 32'h50c) begin failCount++; $display("[TB] FAIL b2b_drained: got valid=%0b addr=%h expected 0/0000050c", out_valid_o, out_addr_o); end
    pushWord(32'h00400213, 1'b0);
    pushWord(32'h00500293, 1'b0);
    pushWord(32'h00600313, 1'b0);
    assertCount++; if (busy_o !== 2'b11) begin failCount++; $display("[TB] FAIL b2b_full_busy: got %b expected 11", busy_o); end
    out_ready_i = 1'b1;
    pushWord(32'h00700393, 1'b0);
    out_ready_i = 1'b0;
    assertCount++; if (out_rdata_o !== 32'h00500293 || busy_o !== 2'b11) begin failCount++; $display("[TB] FAIL b2b_full_swap: got rdata=%h busy=%b expected 00500293/11", out_rdata_o, busy_o); end
    consume();
    consume();
    assertCount++; if (out_rdata_o !== 32'h00700393 || out_addr_o !== 32'h518) begin failCount++; $display("[TB] FAIL b2b_last: got rdata=%h addr=%h expected 00700393/00000518", out_rdata_o, out_addr_o); end
  endtask

  task automatic test_full_clear();
    clearTo(32'h300);
    pushWord(32'h00000013, 1'b0);
    pushWord(32'h00100013, 1'b0);
    pushWord(32'h00200013, 1'b0);
    assertCount++; if (busy_o !== 2'b11) begin failCount++; $display("[TB] FAIL full_busy: got %b expected 11", busy_o); end
    assertCount++; if (out_valid_o !== 1'b1 || out_rdata_o !== 32'h00000013) begin failCount++; $display("[TB] FAIL full_hold: got valid=%0b rdata=%h expected 1/00000013", out_valid_o, out_rdata_o); end
    clear_i    = 1'b1;
    in_addr_i  = 32'h400;
    in_valid_i = 1'b1;
    in_rdata_i = 32'h00300013;
    tick();
    clear_i    = 1'b0;
    in_valid_i = 1'b0;
    assertCount++; if (out_valid_o !== 1'b0 || busy_o !== 2'b00) begin failCount++; $display("[TB] FAIL clear_flush: got valid=%0b busy=%b expected 0/00", out_valid_o, busy_o); end
    assertCount++; if (out_addr_o !== 32'h400) begin failCount++; $display("[TB] FAIL clear_addr: got %h expected 00000400", out_addr_o); end
  endtask

  task automatic test_async_reset();
    clearTo(32'h700);
    pushWord(32'h00000013, 1'b0);
    pushWord(32'h00100013, 1'b0);
    assertCount++; if (busy_o !== 2'b01) begin failCount++; $display("[TB] FAIL rst_pre_busy: got %b expected 01", busy_o); end
    #2;
    rst_ni = 1'b0;
    #1;
    assertCount++; if (out_valid_o !== 1'b0 || busy_o !== 2'b00) begin failCount++; $display("[TB] FAIL rst_async_flush: got valid=%0b busy=%b expected 0/00", out_valid_o, busy_o); end
    assertCount++; if (out_addr_o !== 32'h0) begin failCount++; $display("[TB] FAIL rst_async_addr: got %h expected 00000000", out_addr_o); end
    tick();
    rst_ni = 1'b1;
    tick();
  endtask

  initial begin
    rst_ni      = 1'b0;
    clear_i     = 1'b0;
    in_addr_i   = 32'h0;
    in_valid_i  = 1'b0;
    in_rdata_i  = 32'h0;
    in_err_i    = 1'b0;
    out_ready_i = 1'b0;
    test_reset();
    test_idle_ready();
    test_aligned();
    test_compressed();
    test_unaligned();
    test_error();
    test_back_to_back();
    test_full_clear();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
